// File: rtl/kernel_seq.sv
// kernel_seq: sequences line-buffer addressing for a 3x3 window engine.
// Walks column/row addresses as pixels arrive, tags each accepted pixel and
// delays the tag by LAT cycles so that window qualification lines up with the
// line-buffer outputs.
module kernel_seq #(
  parameter int unsigned LINE_W  = 640,
  parameter int unsigned FRAME_H = 480,
  parameter int unsigned LAT     = 3
) (
  input  logic       readClk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frameStart,
  input  logic       pixValid,
  input  logic       lineEnd,
  output logic [9:0] outX,
  output logic [1:0] outY,
  output logic       winValid,
  output logic [9:0] winX,
  output logic [9:0] winY,
  output logic       frameDone,
  output logic       ovfErr
);

  localparam int unsigned       CNT_W      = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [9:0]        X_LAST     = 10'(LINE_W - 1);
  localparam logic [9:0]        X_HI       = 10'(LINE_W - 2);
  localparam logic [9:0]        ROW_LAST   = 10'(FRAME_H - 1);
  localparam logic [9:0]        ROW_END    = 10'(FRAME_H);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [1:0]         slot_q, slot_d;
  logic [9:0]         row_q, row_d;
  logic               full_q, full_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   drain_q, drain_d;

  logic [LAT-1:0]       tag_v_q, tag_v_d;
  logic [LAT-1:0][9:0]  tag_x_q, tag_x_d;
  logic [LAT-1:0][9:0]  tag_y_q, tag_y_d;

  logic accept;
  logic restart;
  logic interior;
  logic frame_done;

  // Frame sequencing, address walk and overflow detection.
  // outX saturates at the last column, so full_q records that the last column
  // has already been written; only a pixel arriving after that is an overflow.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    slot_d     = slot_q;
    row_d      = row_q;
    full_d     = full_q;
    ovf_d      = ovf_q;
    drain_d    = drain_q;
    accept     = 1'b0;
    restart    = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT_FRAME;
          ovf_d   = 1'b0;
        end
      end

      S_WAIT_FRAME: begin
        if (frameStart) begin
          restart = 1'b1;
        end
      end

      S_ACTIVE: begin
        if (frameStart) begin
          restart = 1'b1;
        end else begin
          if (pixValid) begin
            if (!full_q) begin
              accept = 1'b1;
              if (x_q == X_LAST) begin
                full_d = 1'b1;
              end else begin
                x_d = x_q + 10'd1;
              end
            end else if (lineEnd) begin
              // Last column rewritten by a pixel coinciding with the line end.
              accept = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (lineEnd) begin
            x_d    = '0;
            full_d = 1'b0;
            slot_d = slot_q + 2'd1;
            row_d  = row_q + 10'd1;
            if ((row_q + 10'd1) == ROW_END) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end
        end
      end

      S_DRAIN: begin
        if (frameStart) begin
          restart = 1'b1;
        end else if (drain_q == DRAIN_LAST) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      state_d = S_ACTIVE;
      x_d     = '0;
      slot_d  = '0;
      row_d   = '0;
      full_d  = 1'b0;
    end
  end

  // Tag pipeline: qualify the accepted pixel as a window centre and delay it.
  always_comb begin
    interior = (x_q >= 10'd1) && (x_q <= X_HI) &&
               (row_q >= 10'd2) && (row_q <= ROW_LAST);

    tag_v_d = '0;
    tag_x_d = '0;
    tag_y_d = '0;

    if (!restart) begin
      if (accept && interior) begin
        tag_v_d[0] = 1'b1;
        tag_x_d[0] = x_q - 10'd1;
        tag_y_d[0] = row_q - 10'd1;
      end
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v_d[i] = tag_v_q[i-1];
        tag_x_d[i] = tag_x_q[i-1];
        tag_y_d[i] = tag_y_q[i-1];
      end
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge readClk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      slot_q  <= '0;
      row_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drain_q <= '0;
      tag_v_q <= '0;
      tag_x_q <= '0;
      tag_y_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      drain_q <= drain_d;
      tag_v_q <= tag_v_d;
      tag_x_q <= tag_x_d;
      tag_y_q <= tag_y_d;
    end
  end

  // Output mapping.
  always_comb begin
    outX      = x_q;
    outY      = slot_q;
    winValid  = tag_v_q[LAT-1];
    winX      = tag_x_q[LAT-1];
    winY      = tag_y_q[LAT-1];
    frameDone = frame_done;
    ovfErr    = ovf_q;
  end

endmodule

// File: tb/tb_kernel_seq.sv
// tb_kernel_seq: randomized frames against a timestamp/queue reference model.
module tb_kernel_seq;

  localparam int unsigned LINE_W  = 40;
  localparam int unsigned FRAME_H = 10;
  localparam int unsigned LAT     = 3;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_RUN   = 2;
  localparam int P_FLUSH = 3;

  logic       readClk = 1'b0;
  logic       rst;
  logic       enable;
  logic       frameStart;
  logic       pixValid;
  logic       lineEnd;
  logic [9:0] outX;
  logic [1:0] outY;
  logic       winValid;
  logic [9:0] winX;
  logic [9:0] winY;
  logic       frameDone;
  logic       ovfErr;

  kernel_seq #(
    .LINE_W (LINE_W),
    .FRAME_H(FRAME_H),
    .LAT    (LAT)
  ) dut (
    .readClk   (readClk),
    .rst       (rst),
    .enable    (enable),
    .frameStart(frameStart),
    .pixValid  (pixValid),
    .lineEnd   (lineEnd),
    .outX      (outX),
    .outY      (outY),
    .winValid  (winValid),
    .winX      (winX),
    .winY      (winY),
    .frameDone (frameDone),
    .ovfErr    (ovfErr)
  );

  always #5 readClk = ~readClk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixels-in-line count, row count, and a queue of
  // windows each stamped with the cycle on which it must appear.
  typedef struct {
    int due;
    int x;
    int y;
  } tag_t;

  tag_t m_q[$];
  int   m_phase   = P_IDLE;
  int   m_len     = 0;
  int   m_row     = 0;
  int   m_done_at = 0;
  bit   m_ovf     = 1'b0;
  int   cyc       = 0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_len   = 0;
    m_row   = 0;
    m_ovf   = 1'b0;
    m_q.delete();
  endtask

  task automatic start_frame();
    m_phase = P_RUN;
    m_len   = 0;
    m_row   = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit en, input bit fs, input bit pv, input bit le);
    int x;
    case (m_phase)
      P_IDLE: if (en) begin m_phase = P_ARMED; m_ovf = 1'b0; end
      P_ARMED: if (fs) start_frame();
      P_RUN: begin
        if (fs) start_frame();
        else begin
          if (pv) begin
            if (m_len >= int'(LINE_W)) begin
              if (!le) m_ovf = 1'b1;
            end else begin
              x = m_len;
              if (x >= 1 && x <= int'(LINE_W) - 2 && m_row >= 2 && m_row <= int'(FRAME_H) - 1)
                m_q.push_back('{due: cyc + int'(LAT), x: x - 1, y: m_row - 1});
              m_len++;
            end
          end
          if (le) begin
            m_len = 0;
            m_row++;
            if (m_row == int'(FRAME_H)) begin
              m_phase   = P_FLUSH;
              m_done_at = cyc + int'(LAT);
            end
          end
        end
      end
      P_FLUSH: begin
        if (fs) start_frame();
        else if (cyc == m_done_at) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    cyc++;
  endtask

  task automatic check_outputs(input bit fs);
    int ex;
    ex = (m_len >= int'(LINE_W)) ? int'(LINE_W) - 1 : m_len;
    check("outX", 32'(outX), 32'(ex));
    check("outY", 32'(outY), 32'(m_row % 4));
    check("ovfErr", 32'(ovfErr), 32'(m_ovf));
    check("frameDone", 32'(frameDone),
          (m_phase == P_FLUSH && cyc == m_done_at && !fs) ? 32'd1 : 32'd0);
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      check("winValid", 32'(winValid), 32'd1);
      check("winX", 32'(winX), 32'(m_q[0].x));
      check("winY", 32'(winY), 32'(m_q[0].y));
      void'(m_q.pop_front());
    end else begin
      check("winValid", 32'(winValid), 32'd0);
    end
  endtask

  task automatic check_reset_zero();
    check("rst_outX", 32'(outX), 32'd0);
    check("rst_outY", 32'(outY), 32'd0);
    check("rst_winValid", 32'(winValid), 32'd0);
    check("rst_winX", 32'(winX), 32'd0);
    check("rst_winY", 32'(winY), 32'd0);
    check("rst_frameDone", 32'(frameDone), 32'd0);
    check("rst_ovfErr", 32'(ovfErr), 32'd0);
  endtask

  task automatic drive(input bit en, input bit fs, input bit pv, input bit le);
    enable     = en;
    frameStart = fs;
    pixValid   = pv;
    lineEnd    = le;
    @(negedge readClk);
    check_outputs(fs);
    model_step(en, fs, pv, le);
    @(posedge readClk);
    #1;
  endtask

  task automatic reset_pulse();
    #2;
    rst = 1'b1;
    #1;
    check_reset_zero();
    model_reset();
    @(posedge readClk);
    cyc++;
    @(posedge readClk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  // One line of len pixels; optionally inject a frame restart or reset
  // just before pixel index restart_at / reset_at. Returns 1 on reset.
  task automatic do_line(input int len, input bit gaps, input bit coinc,
                         input int restart_at, input int reset_at, output bit was_reset);
    was_reset = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) drive(rb(), 1'b0, 1'b0, 1'b0);
      if (i == restart_at) drive(rb(), 1'b1, rb(), 1'b0);
      if (i == reset_at) begin
        reset_pulse();
        was_reset = 1'b1;
        return;
      end
      drive(rb(), 1'b0, 1'b1, (i == len - 1) && coinc);
    end
    if (!coinc || len == 0) begin
      if (gaps && rb()) drive(rb(), 1'b0, 1'b0, 1'b0);
      drive(rb(), 1'b0, 1'b0, 1'b1);
    end
  endtask

  // kind 0: full lines, no gaps; kind 1: gaps, short and overlong lines;
  // kind 2: as kind 1 plus occasional mid-frame restart or reset.
  task automatic run_frame(input int kind);
    int lines;
    int restart_line;
    int reset_line;
    bit was_reset;
    restart_line = -1;
    reset_line   = -1;
    if (kind >= 2) begin
      if ($urandom_range(0, 2) == 0) restart_line = int'($urandom_range(1, FRAME_H - 1));
      else if ($urandom_range(0, 2) == 0) reset_line = int'($urandom_range(3, FRAME_H - 2));
    end

    repeat (2) drive(1'b0, 1'b0, rb(), rb());
    drive(1'b1, 1'b0, rb(), rb());
    repeat ($urandom_range(0, 2)) drive(rb(), 1'b0, rb(), rb());
    drive(rb(), 1'b1, rb(), rb());

    lines = 0;
    while (m_phase == P_RUN && lines < 3 * int'(FRAME_H)) begin
      int len;
      int sel;
      int rs_at;
      int rt_at;
      bit coinc;
      sel = int'($urandom_range(0, 9));
      if (kind == 0 || sel < 6 || lines == reset_line) len = int'(LINE_W);
      else if (sel < 8) len = int'($urandom_range(0, LINE_W - 1));
      else len = int'(LINE_W) + int'($urandom_range(1, 6));
      coinc = rb();
      rt_at = (lines == restart_line && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
      rs_at = (lines == reset_line) ? int'(LINE_W) / 2 : -1;
      do_line(len, kind != 0, coinc, rt_at, rs_at, was_reset);
      lines++;
    end

    repeat (LAT + 2) drive(rb(), 1'b0, rb(), rb());
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    frameStart = 1'b0;
    pixValid   = 1'b0;
    lineEnd    = 1'b0;
    #1;
    check_reset_zero();
    @(posedge readClk);
    cyc++;
    @(posedge readClk);
    cyc++;
    #1;
    rst = 1'b0;

    // Inputs other than enable must be ignored while idle after reset.
    repeat (4) drive(1'b0, rb(), rb(), rb());

    run_frame(0);
    run_frame(1);
    for (int f = 0; f < 12; f++) run_frame(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
